// File: rtl/vector_unpermute.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vector_unpermute
// Description : Inverse companion to the vector permute unit. Recovers a
//               3-vector from a row-major 3x3 skew-symmetric matrix held in
//               lanes 0..8 (vee), or re-transposes a 3x3 matrix. Two-stage
//               elastic valid/ready pipeline so writeback backpressure can
//               stall the unit without dropping beats.
//
// Ports       : clk        - clock
//               rst        - asynchronous active-high reset
//               vec_in     - packed input lanes, lane k = matrix element k
//               funct      - 000 vee, 001 transpose, 010 vee (lower triangle)
//               in_valid   - input beat valid
//               in_ready   - unit can accept a beat this cycle
//               vec_out    - result lanes
//               out_valid  - vec_out / err valid
//               out_ready  - downstream accepts the beat
//               err        - skew-consistency violation on current out beat
//               err_count  - saturating count of accepted err beats
//
// Options     : VECTOR_UNPERMUTE_CHECK_EN - when defined, funct 000/010
//               beats are checked for skew symmetry (err, err_count).
//               When undefined, err and err_count are tied to zero.
//
// Revision    : 1.0 - initial release
// ============================================================================
module vector_unpermute #(
    parameter int DATA_WIDTH   = 32,
    parameter int VECTOR_LANES = 16   // must be >= 9
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [VECTOR_LANES*DATA_WIDTH-1:0] vec_in,
    input  logic [2:0]                         funct,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [VECTOR_LANES*DATA_WIDTH-1:0] vec_out,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               err,
    output logic [15:0]                        err_count
);

    localparam int c_VEC_W = VECTOR_LANES * DATA_WIDTH;
    // Only the 3x3 matrix in lanes 0..8 ever reaches the result.
    localparam int c_MAT_W = 9 * DATA_WIDTH;

    localparam logic [2:0] c_FN_VEE       = 3'b000;
    localparam logic [2:0] c_FN_TRANSPOSE = 3'b001;
    localparam logic [2:0] c_FN_VEE_LOWER = 3'b010;

    // Flip the sign bit of a lane.
    function automatic logic [DATA_WIDTH-1:0] f_neg(input logic [DATA_WIDTH-1:0] x);
        return {~x[DATA_WIDTH-1], x[DATA_WIDTH-2:0]};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] f_lane(input logic [c_MAT_W-1:0] v,
                                                     input int k);
        return v[k*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic                r_a_valid;
    logic [c_MAT_W-1:0]  r_a_vec;
    logic [2:0]          r_a_funct;
    logic                r_b_valid;
    logic [c_VEC_W-1:0]  r_b_vec;

    logic                w_ready_a;
    logic                w_in_ready;
    logic [c_VEC_W-1:0]  w_result;
    logic                w_err;

    // Stage B can take stage A's beat when empty or draining this cycle;
    // stage A can take a new beat when empty or moving forward.
    assign w_ready_a  = !r_b_valid || out_ready;
    assign w_in_ready = !r_a_valid || w_ready_a;

    assign in_ready  = w_in_ready;
    assign out_valid = r_b_valid;
    assign vec_out   = r_b_vec;

    // Lanes above the 3x3 matrix are ignored by every operation.
    generate
        if (VECTOR_LANES > 9) begin : g_unused_lanes
            logic w_unused_lanes;
            assign w_unused_lanes = ^vec_in[c_VEC_W-1:c_MAT_W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage A: capture the incoming beat
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_valid <= 1'b0;
            r_a_vec   <= '0;
            r_a_funct <= '0;
        end else if (w_in_ready) begin
            r_a_valid <= in_valid;
            if (in_valid) begin
                r_a_vec   <= vec_in[c_MAT_W-1:0];
                r_a_funct <= funct;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result datapath (from stage A)
    // ------------------------------------------------------------------
    always_comb begin
        w_result = '0;
        case (r_a_funct)
            c_FN_VEE: begin
                w_result[0*DATA_WIDTH +: DATA_WIDTH] = f_lane(r_a_vec, 5);
                w_result[1*DATA_WIDTH +: DATA_WIDTH] = f_lane(r_a_vec, 6);
                w_result[2*DATA_WIDTH +: DATA_WIDTH] = f_lane(r_a_vec, 1);
            end
            c_FN_TRANSPOSE: begin
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        w_result[(3*i+j)*DATA_WIDTH +: DATA_WIDTH] = f_lane(r_a_vec, 3*j+i);
                    end
                end
            end
            c_FN_VEE_LOWER: begin
                w_result[0*DATA_WIDTH +: DATA_WIDTH] = f_neg(f_lane(r_a_vec, 7));
                w_result[1*DATA_WIDTH +: DATA_WIDTH] = f_neg(f_lane(r_a_vec, 2));
                w_result[2*DATA_WIDTH +: DATA_WIDTH] = f_neg(f_lane(r_a_vec, 3));
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Stage B: output register; holds while downstream stalls
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_b_valid <= 1'b0;
            r_b_vec   <= '0;
        end else if (w_ready_a) begin
            r_b_valid <= r_a_valid;
            if (r_a_valid) begin
                r_b_vec <= w_result;
            end
        end
    end

`ifdef VECTOR_UNPERMUTE_CHECK_EN
    localparam logic [DATA_WIDTH-1:0] c_NEG_ZERO = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic        r_b_err;
    logic [15:0] r_err_count;
    logic        w_diag_bad;

    // A skew-symmetric matrix has a zero diagonal (either sign of zero)
    // and each upper element equal to the negated mirrored element.
    always_comb begin
        w_diag_bad = 1'b0;
        for (int d = 0; d < 3; d++) begin
            if (f_lane(r_a_vec, 4*d) != '0 && f_lane(r_a_vec, 4*d) != c_NEG_ZERO) begin
                w_diag_bad = 1'b1;
            end
        end
        w_err = 1'b0;
        if (r_a_funct == c_FN_VEE || r_a_funct == c_FN_VEE_LOWER) begin
            w_err = w_diag_bad
                 || (f_lane(r_a_vec, 5) != f_neg(f_lane(r_a_vec, 7)))
                 || (f_lane(r_a_vec, 6) != f_neg(f_lane(r_a_vec, 2)))
                 || (f_lane(r_a_vec, 1) != f_neg(f_lane(r_a_vec, 3)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_b_err <= 1'b0;
        end else if (w_ready_a && r_a_valid) begin
            r_b_err <= w_err;
        end
    end

    // Counts only beats actually handed downstream; saturates, never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (r_b_valid && out_ready && r_b_err && r_err_count != 16'hFFFF) begin
            r_err_count <= r_err_count + 16'd1;
        end
    end

    assign err       = r_b_err;
    assign err_count = r_err_count;
`else
    assign w_err     = 1'b0;
    assign err       = 1'b0;
    assign err_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vector_unpermute.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_vector_unpermute
// Description : Self-checking bench for vector_unpermute. Directed cases plus
//               randomized traffic compared against a matrix-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_unpermute;

    localparam int DW = 32;
    localparam int NL = 16;
    localparam int VW = DW * NL;

`ifdef VECTOR_UNPERMUTE_CHECK_EN
    localparam bit c_CHECK = 1'b1;
`else
    localparam bit c_CHECK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [VW-1:0] vec_in;
    logic [2:0]    funct;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] vec_out;
    logic          out_valid;
    logic          out_ready;
    logic          err;
    logic [15:0]   err_count;

    always #5 clk = ~clk;

    vector_unpermute #(.DATA_WIDTH(DW), .VECTOR_LANES(NL)) dut (
        .clk       (clk),
        .rst       (rst),
        .vec_in    (vec_in),
        .funct     (funct),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .vec_out   (vec_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .err_count (err_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: works on a 3x3 matrix m[row][col]
    // ------------------------------------------------------------------
    localparam logic [DW-1:0] SIGN = 32'h8000_0000;

    function automatic logic [DW-1:0] ng(input logic [DW-1:0] x);
        return x ^ SIGN;
    endfunction

    function automatic void model(input logic [VW-1:0] v, input logic [2:0] f,
                                  output logic [VW-1:0] o, output logic e);
        logic [DW-1:0] m [3][3];
        logic [DW-1:0] r [NL];
        for (int row = 0; row < 3; row++)
            for (int col = 0; col < 3; col++)
                m[row][col] = v[(3*row+col)*DW +: DW];
        for (int k = 0; k < NL; k++) r[k] = '0;
        case (f)
            3'b000: begin r[0] = m[1][2]; r[1] = m[2][0]; r[2] = m[0][1]; end
            3'b001: for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++) r[3*i+j] = m[j][i];
            3'b010: begin r[0] = ng(m[2][1]); r[1] = ng(m[0][2]); r[2] = ng(m[1][0]); end
            default: ;
        endcase
        e = 1'b0;
        if (c_CHECK && (f == 3'b000 || f == 3'b010)) begin
            for (int d = 0; d < 3; d++)
                if (m[d][d] != 0 && m[d][d] != SIGN) e = 1'b1;
            if (m[1][2] != ng(m[2][1])) e = 1'b1;
            if (m[2][0] != ng(m[0][2])) e = 1'b1;
            if (m[0][1] != ng(m[1][0])) e = 1'b1;
        end
        o = '0;
        for (int k = 0; k < NL; k++) o[k*DW +: DW] = r[k];
    endfunction

    function automatic logic [VW-1:0] rand_beat();
        logic [VW-1:0] v;
        logic [DW-1:0] a, b, c;
        int mode;
        for (int k = 0; k < NL; k++) v[k*DW +: DW] = $urandom;
        mode = $urandom_range(0, 2);
        if (mode != 0) begin
            a = $urandom; b = $urandom; c = $urandom;
            v[5*DW +: DW] = a; v[7*DW +: DW] = ng(a);
            v[6*DW +: DW] = b; v[2*DW +: DW] = ng(b);
            v[1*DW +: DW] = c; v[3*DW +: DW] = ng(c);
            for (int d = 0; d < 3; d++) v[4*d*DW +: DW] = ($urandom_range(0, 1) != 0) ? SIGN : '0;
            if (mode == 2) v[$urandom_range(0, 8)*DW + $urandom_range(0, DW-1)] ^= 1'b1;
        end
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Monitor / scoreboard (samples on the falling edge)
    // ------------------------------------------------------------------
    logic [VW-1:0] exp_v [$];
    logic          exp_e [$];
    logic [15:0]   model_cnt = '0;
    logic          hold_pend = 1'b0;
    logic [VW-1:0] held_v;
    logic          held_e;

    always @(negedge clk) begin
        logic [VW-1:0] o;
        logic          e;
        if (rst) begin
            exp_v.delete();
            exp_e.delete();
            model_cnt = '0;
            hold_pend = 1'b0;
        end else begin
            check("err_count", err_count, model_cnt);
            if (hold_pend) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_vec", vec_out, held_v);
                check("hold_err", err, held_e);
            end
            hold_pend = out_valid && !out_ready;
            held_v    = vec_out;
            held_e    = err;
            if (out_valid && out_ready) begin
                if (exp_v.size() == 0) begin
                    check("spurious_out", 1'b1, 1'b0);
                end else begin
                    o = exp_v.pop_front();
                    e = exp_e.pop_front();
                    check("out_vec", vec_out, o);
                    check("out_err", err, e);
                    if (e && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
                end
            end
            if (in_valid && in_ready) begin
                model(vec_in, funct, o, e);
                exp_v.push_back(o);
                exp_e.push_back(e);
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers (entered and left at #1 after a rising edge)
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [VW-1:0] v, input logic [2:0] f);
        in_valid = 1'b1;
        vec_in   = v;
        funct    = f;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (in_ready) break;
            if (t > 100) begin
                check("send_timeout", 1'b0, 1'b1);
                break;
            end
            step();
        end
        step();
        in_valid = 1'b0;
    endtask

    function automatic logic [VW-1:0] lanes9(input logic [DW-1:0] l0, l1, l2, l3, l4,
                                             l5, l6, l7, l8);
        logic [VW-1:0] v;
        v = '0;
        v[0*DW +: DW] = l0; v[1*DW +: DW] = l1; v[2*DW +: DW] = l2;
        v[3*DW +: DW] = l3; v[4*DW +: DW] = l4; v[5*DW +: DW] = l5;
        v[6*DW +: DW] = l6; v[7*DW +: DW] = l7; v[8*DW +: DW] = l8;
        return v;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] skew, vexp, bp [4];
        int acc;

        rst = 1'b1; in_valid = 1'b0; vec_in = '0; funct = '0; out_ready = 1'b1;
        #12;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_vec_out", vec_out, '0);
        check("rst_err", err, 1'b0);
        check("rst_err_count", err_count, 16'h0);
        step();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1'b1);

        // Vee round trip with two-edge latency
        skew = lanes9(32'h0, 32'h40400000, 32'hC0000000, 32'hC0400000, 32'h0,
                      32'h3F800000, 32'h40000000, 32'hBF800000, 32'h0);
        vexp = lanes9(32'h3F800000, 32'h40000000, 32'h40400000, 0, 0, 0, 0, 0, 0);
        send(skew, 3'b000);
        check("vee_lat_early", out_valid, 1'b0);
        step();
        check("vee_lat_valid", out_valid, 1'b1);
        check("vee_vec", vec_out, vexp);
        check("vee_err", err, 1'b0);
        step();

        // Lower-triangle vee on the same matrix
        send(skew, 3'b010);
        step();
        check("lvee_vec", vec_out, vexp);
        check("lvee_err", err, 1'b0);
        step();

        // Transpose
        send(lanes9(1, 2, 3, 4, 5, 6, 7, 8, 9), 3'b001);
        step();
        check("tr_vec", vec_out, lanes9(1, 4, 7, 2, 5, 8, 3, 6, 9));
        step();

        // Inconsistent skew matrix
        check("bad_cnt_before", err_count, 16'h0);
        send(lanes9(0, 0, 0, 0, 0, 32'h3F800000, 0, 32'h3F800000, 0), 3'b000);
        step();
        check("bad_err", err, c_CHECK);
        step();
        check("bad_cnt_after", err_count, c_CHECK ? 16'h1 : 16'h0);

        // Backpressure: 4 back-to-back beats, out_ready low for 3 cycles
        for (int k = 0; k < 4; k++) bp[k] = rand_beat();
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; vec_in = bp[acc]; funct = 3'b001;
            @(negedge clk);
            if (in_ready) acc++;
            step();
        end
        check("bp_accepted", acc, 2);
        check("bp_in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        for (int t = 0; acc < 4; t++) begin
            in_valid = 1'b1; vec_in = bp[acc]; funct = 3'b001;
            @(negedge clk);
            if (in_ready) acc++;
            step();
            if (t > 20) begin
                check("bp_timeout", 1'b0, 1'b1);
                break;
            end
        end
        in_valid = 1'b0;
        repeat (4) step();
        check("bp_drain", exp_v.size(), 0);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            vec_in    = rand_beat();
            funct     = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) step();
        check("rand_drain", exp_v.size(), 0);

        // Reset with both stages full
        out_ready = 1'b0;
        in_valid = 1'b1; vec_in = rand_beat(); funct = 3'b001;
        step();
        vec_in = rand_beat();
        step();
        in_valid = 1'b0;
        check("mid_full", out_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_vec", vec_out, '0);
        check("mid_rst_err", err, 1'b0);
        step();
        rst = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check("mid_no_stale", out_valid, 1'b0);
            step();
        end

        // Stream of inconsistent beats: counter saturates (or stays 0)
        in_valid = 1'b1; funct = 3'b000;
        vec_in = lanes9(0, 0, 0, 0, 0, 32'h3F800000, 0, 32'h3F800000, 0);
        repeat (c_CHECK ? 65540 : 300) @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) step();
        check("sat_count", err_count, c_CHECK ? 16'hFFFF : 16'h0);
        check("sat_drain", exp_v.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
